// File: rtl/controller_pkg.sv
// controller_pkg: state, opcode and mux-select encodings shared by the multicycle controller
package controller_pkg;
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
        MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7,
        ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10, TRAP = 4'd15
    } state_t;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_BR = 2'b01, ALU_FN = 2'b10} aluop_t;
    typedef enum logic [1:0] {SA_PC = 2'b00, SA_OLDPC = 2'b01, SA_RS1 = 2'b10} srca_t;
    typedef enum logic [1:0] {SB_RS2 = 2'b00, SB_IMM = 2'b01, SB_FOUR = 2'b10} srcb_t;
    typedef enum logic [1:0] {RS_ALUOUT = 2'b00, RS_MEM = 2'b01, RS_ALU = 2'b10} res_t;
    typedef struct packed {
        logic   fetch;
        logic   pc_update;
        logic   branch;
        logic   adr_src;
        logic   mem_read;
        logic   mem_write;
        logic   reg_write;
        logic   trap;
        srca_t  src_a;
        srcb_t  src_b;
        aluop_t alu_op;
        res_t   result_src;
    } ctrl_t;
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.fetch = 1'b1; c.mem_read = 1'b1; c.src_b = SB_FOUR; c.result_src = RS_ALU; end
            DECODE:   begin c.src_a = SA_OLDPC; c.src_b = SB_IMM; end
            MEMADR:   begin c.src_a = SA_RS1; c.src_b = SB_IMM; end
            MEMREAD:  begin c.adr_src = 1'b1; c.mem_read = 1'b1; end
            MEMWB:    begin c.result_src = RS_MEM; c.reg_write = 1'b1; end
            MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
            EXECR:    begin c.src_a = SA_RS1; c.alu_op = ALU_FN; end
            EXECI:    begin c.src_a = SA_RS1; c.src_b = SB_IMM; c.alu_op = ALU_FN; end
            ALUWB:    c.reg_write = 1'b1;
            BEQ:      begin c.src_a = SA_RS1; c.alu_op = ALU_BR; c.branch = 1'b1; end
            JAL:      begin c.src_a = SA_OLDPC; c.src_b = SB_FOUR; c.pc_update = 1'b1; end
            default:  c.trap = 1'b1;
        endcase
        return c;
    endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: saturating memory-wait counter flagging when the wait limit is reached
// clk, reset: clock and synchronous active-high reset
// clr: zero the count; en: count one wait cycle
// at_limit: count equals 2**W-1
module mem_wait_timer #(
    parameter int W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic at_limit
);
    logic [W-1:0] count;
    assign at_limit = &count;
    always_ff @(posedge clk)
        if (reset || clr) count <= '0;
        else if (en && !at_limit) count <= count + 1'b1;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multi-cycle main control FSM with memory wait and sticky trap
// clk, reset: clock and synchronous active-high reset
// Opcode: IR[6:0]; mem_ready: memory completes the current access
// PCUpdate..ResultSrc: datapath strobes and mux selects; trap: sticky error; state_o: current state
module multicycle_controller
    import controller_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int TIMEOUT_W     = 4,
    parameter int EN_JUMP       = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Opcode,
    input  logic       mem_ready,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ResultSrc,
    output logic       trap,
    output logic [3:0] state_o
);
    state_t state, state_n;
    ctrl_t  ctrl;
    logic   wait_st, done, tmo;
    assign wait_st = state inside {FETCH, MEMREAD, MEMWRITE};
    assign done    = (MEM_HANDSHAKE == 0) || mem_ready;
    if (MEM_HANDSHAKE != 0) begin : g_timer
        logic at_limit;
        // counter is held at zero outside wait states and on completion, so every entry starts from 0
        mem_wait_timer #(.W(TIMEOUT_W)) u_timer (
            .clk(clk), .reset(reset), .clr(!wait_st || mem_ready),
            .en(wait_st && !mem_ready), .at_limit(at_limit)
        );
        assign tmo = at_limit && wait_st && !mem_ready;
    end else begin : g_no_timer
        assign tmo = 1'b0;
    end
    always_comb begin
        state_n = state;
        case (state)
            FETCH:    state_n = done ? DECODE : tmo ? TRAP : FETCH;
            DECODE:
                case (Opcode)
                    OP_LOAD, OP_STORE: state_n = MEMADR;
                    OP_RTYPE:          state_n = EXECR;
                    OP_ITYPE:          state_n = EXECI;
                    OP_BRANCH:         state_n = BEQ;
                    OP_JAL:            state_n = (EN_JUMP != 0) ? JAL : TRAP;
                    default:           state_n = TRAP;
                endcase
            MEMADR:   state_n = (Opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_n = done ? MEMWB : tmo ? TRAP : MEMREAD;
            MEMWB:    state_n = FETCH;
            MEMWRITE: state_n = done ? FETCH : tmo ? TRAP : MEMWRITE;
            EXECR:    state_n = ALUWB;
            EXECI:    state_n = ALUWB;
            ALUWB:    state_n = FETCH;
            BEQ:      state_n = FETCH;
            JAL:      state_n = ALUWB;
            default:  state_n = TRAP;
        endcase
    end
    // outputs are registered by decoding the next state, so they are exactly the Moore values of state
    always_ff @(posedge clk)
        if (reset) begin
            state <= FETCH;
            ctrl  <= decode_ctrl(FETCH);
        end else begin
            state <= state_n;
            ctrl  <= decode_ctrl(state_n);
        end
    assign IRWrite   = ctrl.fetch && done;
    assign PCUpdate  = ctrl.pc_update || (ctrl.fetch && done);
    assign Branch    = ctrl.branch;
    assign AdrSrc    = ctrl.adr_src;
    assign MemRead   = ctrl.mem_read;
    assign MemWrite  = ctrl.mem_write;
    assign RegWrite  = ctrl.reg_write;
    assign ALUSrcA   = ctrl.src_a;
    assign ALUSrcB   = ctrl.src_b;
    assign ALUOp     = ctrl.alu_op;
    assign ResultSrc = ctrl.result_src;
    assign trap      = ctrl.trap;
    assign state_o   = state;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table-driven and directed checks of the multicycle controller
module tb_multicycle_controller;
    localparam logic [6:0] ADD = 7'b0110011, LW = 7'b0000011, SW = 7'b0100011;
    localparam logic [6:0] BQO = 7'b1100011, JLO = 7'b1101111, ADDI = 7'b0010011, ILL = 7'b0000000;
    logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b1;
    logic [6:0] Opcode = 7'd0;
    wire [3:0][15:0] ob;
    wire [3:0][3:0] st;
    int errors = 0, checks = 0;
    logic [15:0] FR, FW, DEC, MADR, MRD, MWB, MWR, EXR, EXI, AWB, BQ, JL, TRP;
    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [15:0] out;
    } vec_t;
    vec_t tv[$];
    always #5 clk = ~clk;
    genvar g;
    for (g = 0; g < 4; g++) begin : g_dut
        multicycle_controller #(
            .MEM_HANDSHAKE(g == 3 ? 0 : 1), .TIMEOUT_W(g == 2 ? 2 : 4), .EN_JUMP(g == 1 ? 0 : 1)
        ) u (
            .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
            .PCUpdate(ob[g][15]), .Branch(ob[g][14]), .IRWrite(ob[g][13]), .AdrSrc(ob[g][12]),
            .MemRead(ob[g][11]), .MemWrite(ob[g][10]), .RegWrite(ob[g][9]),
            .ALUSrcA(ob[g][8:7]), .ALUSrcB(ob[g][6:5]), .ALUOp(ob[g][4:3]),
            .ResultSrc(ob[g][2:1]), .trap(ob[g][0]), .state_o(st[g])
        );
    end
    function automatic logic [15:0] o(input bit pcu, br, irw, adr, mr, mw, rw,
                                      input logic [1:0] asa, asb, aop, rs, input bit tr);
        return {pcu, br, irw, adr, mr, mw, rw, asa, asb, aop, rs, tr};
    endfunction
    task automatic chk(input string name, input int idx, input logic [15:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s #%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    initial begin
        FR   = o(1,0,1,0,1,0,0,2'b00,2'b10,2'b00,2'b10,0);
        FW   = o(0,0,0,0,1,0,0,2'b00,2'b10,2'b00,2'b10,0);
        DEC  = o(0,0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0);
        MADR = o(0,0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0);
        MRD  = o(0,0,0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,0);
        MWB  = o(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b01,0);
        MWR  = o(0,0,0,1,0,1,0,2'b00,2'b00,2'b00,2'b00,0);
        EXR  = o(0,0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0);
        EXI  = o(0,0,0,0,0,0,0,2'b10,2'b01,2'b10,2'b00,0);
        AWB  = o(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0);
        BQ   = o(0,1,0,0,0,0,0,2'b10,2'b00,2'b01,2'b00,0);
        JL   = o(1,0,0,0,0,0,0,2'b01,2'b10,2'b00,2'b00,0);
        TRP  = o(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1);
        tv = '{
            '{0, ADD, 1, 0, FR}, '{0, ADD, 1, 1, DEC}, '{0, ADD, 1, 6, EXR}, '{0, ADD, 1, 8, AWB},
            '{0, LW, 1, 0, FR}, '{0, LW, 1, 1, DEC}, '{0, LW, 1, 2, MADR}, '{0, LW, 0, 3, MRD},
            '{0, LW, 0, 3, MRD}, '{0, LW, 0, 3, MRD}, '{0, LW, 1, 3, MRD}, '{0, LW, 1, 4, MWB},
            '{0, SW, 1, 0, FR}, '{0, SW, 1, 1, DEC}, '{0, SW, 1, 2, MADR}, '{0, SW, 1, 5, MWR},
            '{0, BQO, 1, 0, FR}, '{0, BQO, 1, 1, DEC}, '{0, BQO, 1, 9, BQ},
            '{0, JLO, 1, 0, FR}, '{0, JLO, 1, 1, DEC}, '{0, JLO, 1, 10, JL}, '{0, JLO, 1, 8, AWB},
            '{0, ADDI, 0, 0, FW}, '{0, ADDI, 1, 0, FR}, '{0, ADDI, 1, 1, DEC}, '{0, ADDI, 1, 7, EXI},
            '{0, ADDI, 1, 8, AWB},
            '{0, ILL, 1, 0, FR}, '{0, ILL, 1, 1, DEC}, '{0, ILL, 1, 15, TRP}, '{0, ILL, 1, 15, TRP},
            '{1, ILL, 1, 15, TRP}, '{0, ADD, 0, 0, FW}
        };
        cyc();
        cyc();
        for (int i = 0; i < tv.size(); i++) begin
            reset = tv[i].rst;
            Opcode = tv[i].op;
            mem_ready = tv[i].rdy;
            #1;
            chk("vec_state", i, 16'(st[0]), 16'(tv[i].st));
            chk("vec_outs", i, ob[0], tv[i].out);
            cyc();
        end
        reset = 1'b1; mem_ready = 1'b1; Opcode = JLO;
        cyc();
        reset = 1'b0;
        chk("nojump_fetch", 0, 16'(st[1]), 16'd0);
        cyc();
        chk("nojump_decode", 0, 16'(st[1]), 16'd1);
        cyc();
        for (int k = 0; k < 20; k++) begin
            chk("nojump_trap_state", k, 16'(st[1]), 16'd15);
            chk("nojump_trap_outs", k, ob[1], TRP);
            cyc();
        end
        reset = 1'b1; mem_ready = 1'b0;
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("tmo_wait_state", k, 16'(st[2]), 16'd0);
            cyc();
        end
        chk("tmo_trap_state", 0, 16'(st[2]), 16'd15);
        chk("tmo_trap_flag", 0, 16'(ob[2][0]), 16'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("late_wait_state", k, 16'(st[2]), 16'd0);
            cyc();
        end
        mem_ready = 1'b1;
        #1;
        chk("late_irwrite", 0, 16'(ob[2][13]), 16'd1);
        cyc();
        chk("late_decode_state", 0, 16'(st[2]), 16'd1);
        chk("late_no_trap", 0, 16'(ob[2][0]), 16'd0);
        reset = 1'b1; mem_ready = 1'b1; Opcode = SW;
        cyc();
        reset = 1'b0;
        cyc();
        cyc();
        cyc();
        mem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("swwait_state", k, 16'(st[0]), 16'd5);
            chk("swwait_memwrite", k, 16'(ob[0][10]), 16'd1);
            chk("swwait_state_t2", k, 16'(st[2]), 16'd5);
            if (k == 1) reset = 1'b1;
            cyc();
        end
        reset = 1'b0; Opcode = ADD;
        chk("swrst_state", 0, 16'(st[0]), 16'd0);
        chk("swrst_memwrite", 0, 16'(ob[0][10]), 16'd0);
        for (int k = 0; k < 4; k++) begin
            chk("swrst_count_state", k, 16'(st[2]), 16'd0);
            cyc();
        end
        chk("swrst_count_trap", 0, 16'(st[2]), 16'd15);
        reset = 1'b1; mem_ready = 1'b0; Opcode = LW;
        cyc();
        reset = 1'b0;
        #1;
        chk("nohs_irwrite", 0, 16'(ob[3][13]), 16'd1);
        cyc();
        chk("nohs_decode", 0, 16'(st[3]), 16'd1);
        cyc();
        cyc();
        chk("nohs_memread", 0, 16'(st[3]), 16'd3);
        cyc();
        chk("nohs_memwb", 0, 16'(st[3]), 16'd4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
